// File: rtl/sr04_ctrl.sv
// sr04_ctrl: HC-SR04 measurement sequencer.
// Drives the external us/ms time base through o_idle/o_run and issues the trigger pulse.
// It times the echo pulse and converts the echo width to centimetres with a
// 14-step restoring divider. It then holds off before the next trigger.

module sr04_ctrl #(
   parameter int TRIG_US      = 10,
   parameter int ECHO_WAIT_MS = 4,
   parameter int ECHO_MAX_MS  = 38,
   parameter int HOLDOFF_MS   = 60
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_start,
   input  logic        i_echo,
   input  logic [13:0] i_us_cnt,
   input  logic [5:0]  i_ms_cnt,
   output logic        o_idle,
   output logic        o_run,
   output logic        o_trig,
   output logic        o_busy,
   output logic        o_valid,
   output logic        o_timeout,
   output logic [13:0] o_echo_us,
   output logic [8:0]  o_dist_cm
);

   localparam logic [13:0] TRIG_LIMIT = 14'(TRIG_US);
   localparam logic [5:0]  WAIT_LIMIT = 6'(ECHO_WAIT_MS);
   localparam logic [5:0]  MAX_LIMIT  = 6'(ECHO_MAX_MS);
   localparam logic [5:0]  HOLD_LIMIT = 6'(HOLDOFF_MS);
   localparam logic [13:0] ECHO_SAT   = 14'h3FFF;
   localparam logic [6:0]  CM_DIVISOR = 7'd58;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TRIG,
      ST_RESTART,
      ST_WAIT_ECHO,
      ST_MEASURE,
      ST_CALC,
      ST_HOLDOFF
   } stateT;

   stateT       r_state;
   stateT       r_after;
   logic        r_postRestart;
   logic        r_echoMeta;
   logic        r_echoSync;
   logic        r_echoPrev;
   logic [13:0] r_width;
   logic [13:0] r_divQuo;
   logic [5:0]  r_divRem;
   logic [3:0]  r_divCnt;
   logic        r_idle;
   logic        r_run;
   logic        r_trig;
   logic        r_busy;
   logic        r_valid;
   logic        r_timeout;
   logic [13:0] r_echoUs;
   logic [8:0]  r_distCm;

   stateT       w_nextState;
   stateT       w_nextAfter;
   logic        w_nextIdle;
   logic        w_nextRun;
   logic        w_nextTrig;
   logic        w_nextBusy;
   logic        w_nextValid;
   logic        w_nextTimeout;
   logic [13:0] w_nextEchoUs;
   logic [8:0]  w_nextDist;
   logic [13:0] w_nextWidth;
   logic [13:0] w_nextQuo;
   logic [5:0]  w_nextRem;
   logic [3:0]  w_nextCnt;

   logic        w_echoRise;
   logic        w_echoFall;
   logic        w_cntOk;
   logic        w_wrapped;
   logic [13:0] w_measured;
   logic [6:0]  w_remShift;
   logic        w_remGe;
   logic [13:0] w_quoShift;

   // Edges come from the synchronized echo and its previous sample, so rise and fall see equal latency.
   assign w_echoRise = r_echoSync & ~r_echoPrev;
   assign w_echoFall = ~r_echoSync & r_echoPrev;

   // Counts are stale during a restart and on the cycle after it.
   assign w_cntOk = ~r_postRestart;

   // The us count wraps at 16384; the ms count tells us whether that has happened.
   assign w_wrapped  = (i_ms_cnt > 6'd16) || ((i_ms_cnt == 6'd16) && (i_us_cnt < 14'd16000));
   assign w_measured = w_wrapped ? ECHO_SAT : i_us_cnt;

   // One restoring-division step: bring in the next dividend bit and try subtracting 58.
   assign w_remShift = {r_divRem, r_divQuo[13]};
   assign w_remGe    = (w_remShift >= CM_DIVISOR);
   assign w_quoShift = {r_divQuo[12:0], w_remGe};

   assign o_idle    = r_idle;
   assign o_run     = r_run;
   assign o_trig    = r_trig;
   assign o_busy    = r_busy;
   assign o_valid   = r_valid;
   assign o_timeout = r_timeout;
   assign o_echo_us = r_echoUs;
   assign o_dist_cm = r_distCm;

   // Two-flop synchronizer for the asynchronous echo, plus one more sample for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_echoMeta <= 1'b0;
         r_echoSync <= 1'b0;
         r_echoPrev <= 1'b0;
      end else begin
         r_echoMeta <= i_echo;
         r_echoSync <= r_echoMeta;
         r_echoPrev <= r_echoSync;
      end
   end

   // Next-state, divider and result logic; the time-base controls follow the next state so they come out registered.
   always_comb begin
      w_nextState   = r_state;
      w_nextAfter   = r_after;
      w_nextValid   = 1'b0;
      w_nextTimeout = r_timeout;
      w_nextEchoUs  = r_echoUs;
      w_nextDist    = r_distCm;
      w_nextWidth   = r_width;
      w_nextQuo     = r_divQuo;
      w_nextRem     = r_divRem;
      w_nextCnt     = r_divCnt;
      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               w_nextState = ST_TRIG;
            end
         end
         ST_TRIG: begin
            if (w_cntOk && (i_us_cnt >= TRIG_LIMIT)) begin
               w_nextState = ST_RESTART;
               w_nextAfter = ST_WAIT_ECHO;
            end
         end
         ST_RESTART: begin
            w_nextState = r_after;
         end
         ST_WAIT_ECHO: begin
            if (w_echoRise) begin
               w_nextState = ST_RESTART;
               w_nextAfter = ST_MEASURE;
            end else if (w_cntOk && (i_ms_cnt >= WAIT_LIMIT)) begin
               w_nextState   = ST_RESTART;
               w_nextAfter   = ST_HOLDOFF;
               w_nextValid   = 1'b1;
               w_nextTimeout = 1'b1;
               w_nextEchoUs  = '0;
               w_nextDist    = '0;
            end
         end
         ST_MEASURE: begin
            if (w_echoFall) begin
               w_nextWidth = w_measured;
               w_nextQuo   = w_measured;
               w_nextRem   = '0;
               w_nextCnt   = '0;
               w_nextState = ST_CALC;
            end else if (w_cntOk && (i_ms_cnt >= MAX_LIMIT)) begin
               w_nextState   = ST_RESTART;
               w_nextAfter   = ST_HOLDOFF;
               w_nextValid   = 1'b1;
               w_nextTimeout = 1'b1;
               w_nextEchoUs  = ECHO_SAT;
               w_nextDist    = '0;
            end
         end
         ST_CALC: begin
            w_nextQuo = w_quoShift;
            w_nextRem = w_remGe ? 6'(w_remShift - CM_DIVISOR) : w_remShift[5:0];
            w_nextCnt = r_divCnt + 4'd1;
            if (r_divCnt == 4'd13) begin
               w_nextState   = ST_RESTART;
               w_nextAfter   = ST_HOLDOFF;
               w_nextValid   = 1'b1;
               w_nextTimeout = 1'b0;
               w_nextEchoUs  = r_width;
               w_nextDist    = w_quoShift[8:0];
            end
         end
         ST_HOLDOFF: begin
            if (w_cntOk && (i_ms_cnt >= HOLD_LIMIT)) begin
               w_nextState = ST_IDLE;
            end
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
      w_nextIdle = (w_nextState == ST_IDLE) || (w_nextState == ST_RESTART);
      w_nextRun  = ~w_nextIdle;
      w_nextTrig = (w_nextState == ST_TRIG);
      w_nextBusy = (w_nextState != ST_IDLE);
   end

   // State, divider and output registers; reset returns every output to its idle value at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_after       <= ST_IDLE;
         r_postRestart <= 1'b0;
         r_width       <= '0;
         r_divQuo      <= '0;
         r_divRem      <= '0;
         r_divCnt      <= '0;
         r_idle        <= 1'b1;
         r_run         <= 1'b0;
         r_trig        <= 1'b0;
         r_busy        <= 1'b0;
         r_valid       <= 1'b0;
         r_timeout     <= 1'b0;
         r_echoUs      <= '0;
         r_distCm      <= '0;
      end else begin
         r_state       <= w_nextState;
         r_after       <= w_nextAfter;
         r_postRestart <= (r_state == ST_RESTART);
         r_width       <= w_nextWidth;
         r_divQuo      <= w_nextQuo;
         r_divRem      <= w_nextRem;
         r_divCnt      <= w_nextCnt;
         r_idle        <= w_nextIdle;
         r_run         <= w_nextRun;
         r_trig        <= w_nextTrig;
         r_busy        <= w_nextBusy;
         r_valid       <= w_nextValid;
         r_timeout     <= w_nextTimeout;
         r_echoUs      <= w_nextEchoUs;
         r_distCm      <= w_nextDist;
      end
   end

endmodule
